// File: rtl/fir_round_decimate.sv
// FIR post-processing: decimation with frame-aligned phase select, convergent rounding,
// saturation, and a small output FIFO with valid/ready toward the consumer.
module fir_round_decimate #(
  parameter int IN_WIDTH   = 26,
  parameter int OUT_WIDTH  = 16,
  parameter int DROP_LSB   = 10,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           valid_in,
  input  logic signed [IN_WIDTH-1:0]                     din,
  input  logic [((DECIM > 1) ? $clog2(DECIM) : 1)-1:0]   phase_sel,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic signed [OUT_WIDTH-1:0]                    dout,
  output logic [$clog2(FIFO_DEPTH):0]                    fifo_level,
  output logic                                           sat_flag,
  output logic                                           overflow,
  input  logic                                           flags_clr
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = IN_WIDTH - DROP_LSB + 1;

  // ---------------- decimation ----------------
  logic [PW-1:0] cnt, phase_ph;
  logic          wrap, keep;

  assign wrap = valid_in && (cnt == PW'(DECIM - 1));
  assign keep = valid_in && ((DECIM == 1) || (cnt == phase_ph));

  // phase_ph only reloads on a frame boundary so a frame keeps exactly one sample
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      phase_ph <= phase_sel;
    end else if (valid_in) begin
      if (wrap) begin
        cnt      <= '0;
        phase_ph <= phase_sel;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // ---------------- input capture ----------------
  logic                s0_valid;
  logic [IN_WIDTH-1:0] s0_din;

  always_ff @(posedge clk) begin
    if (rst) s0_valid <= 1'b0;
    else     s0_valid <= keep;
    s0_din <= din;
  end

  // ---------------- stage 1: round half to even ----------------
  logic [RW-1:0] rnd;

  if (DROP_LSB == 0) begin : g_noround
    assign rnd = {s0_din[IN_WIDTH-1], s0_din};
  end else begin : g_round
    localparam logic [DROP_LSB-1:0] HALF = DROP_LSB'(1) << (DROP_LSB - 1);
    logic [DROP_LSB-1:0] frac;
    logic                up;
    assign frac = s0_din[DROP_LSB-1:0];
    assign up   = (frac > HALF) || ((frac == HALF) && s0_din[DROP_LSB]);
    // floor via arithmetic truncation, then one extra sign bit so +1 cannot wrap
    assign rnd  = {s0_din[IN_WIDTH-1], s0_din[IN_WIDTH-1:DROP_LSB]} + RW'(up);
  end

  logic          s1_valid;
  logic [RW-1:0] s1_r;

  always_ff @(posedge clk) begin
    if (rst) s1_valid <= 1'b0;
    else     s1_valid <= s0_valid;
    s1_r <= rnd;
  end

  // ---------------- stage 2: saturation ----------------
  logic [RW-OUT_WIDTH:0] hi;
  logic                  clamp;
  logic [OUT_WIDTH-1:0]  sat_val;

  assign hi      = s1_r[RW-1:OUT_WIDTH-1];
  assign clamp   = !((&hi) || !(|hi));
  assign sat_val = {s1_r[RW-1], {(OUT_WIDTH-1){~s1_r[RW-1]}}};

  logic                 s2_valid, s2_sat;
  logic [OUT_WIDTH-1:0] s2_d;

  always_ff @(posedge clk) begin
    if (rst) s2_valid <= 1'b0;
    else     s2_valid <= s1_valid;
    s2_d   <= clamp ? sat_val : s1_r[OUT_WIDTH-1:0];
    s2_sat <= clamp;
  end

  // ---------------- output FIFO ----------------
  logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level;
  logic                 empty, full, pop, push, drop;

  assign empty = (level == '0);
  assign full  = (level == LW'(FIFO_DEPTH));
  assign pop   = !empty && out_ready;
  assign push  = s2_valid && (!full || pop);
  assign drop  = s2_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s2_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  // set events outrank a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sat_flag <= (s2_valid && s2_sat) || (sat_flag && !flags_clr);
      overflow <= drop || (overflow && !flags_clr);
    end
  end

  assign out_valid  = !empty;
  assign dout       = empty ? '0 : mem[rd_ptr];
  assign fifo_level = level;

endmodule

// File: doc/fir_round_decimate.md
Name: fir_round_decimate

Overview:
- Post-processing stage directly downstream of the systolic FIR filters.
- Takes the full-precision filter output (din/valid_in, one cycle per valid sample) and applies convergent rounding to drop LSBs, then saturation to the output width.
- Decimates by an integer factor with a selectable phase.
- Buffers results in a small FIFO with a valid/ready interface toward the consumer, because the FIR output has no backpressure.

Parameters:
- IN_WIDTH, 26, width of signed input sample (FIR OUTPUT_WIDTH).
- OUT_WIDTH, 16, width of signed output sample; must be <= IN_WIDTH - DROP_LSB + 1.
- DROP_LSB, 10, LSBs removed by rounding; 0 = no rounding.
- DECIM, 4, decimation factor, >= 1; 1 = pass every sample.
- FIFO_DEPTH, 8, output FIFO entries, power of 2, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- valid_in  in  1  din qualifier, one sample per high cycle
- din  in  IN_WIDTH  signed filter output
- phase_sel  in  max(1,$clog2(DECIM))  decimation phase kept, 0..DECIM-1
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head when out_valid & out_ready
- dout  out  OUT_WIDTH  signed FIFO head sample
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- sat_flag  out  1  sticky: a saturation occurred
- overflow  out  1  sticky: a sample was dropped because the FIFO was full
- flags_clr  in  1  clears sat_flag and overflow

Behaviour:
- Reset (rst=1 at posedge):
  - Phase counter = 0; pipeline valids = 0; FIFO empty.
  - Outputs: out_valid=0, dout=0, fifo_level=0, sat_flag=0, overflow=0.
  - rst overrides every other input, including a valid_in in the same cycle; an in-flight pipeline sample is discarded.
- Decimation:
  - Counter cnt increments on each valid_in and wraps from DECIM-1 to 0.
  - Sample is kept iff valid_in & (cnt == phase_ph).
  - phase_ph is phase_sel registered at reset and whenever cnt wraps to 0, so a mid-frame phase_sel change never drops or doubles a sample within a frame.
  - phase_sel >= DECIM: no sample is kept.
  - DECIM=1: every valid sample is kept and phase_sel is ignored.
- Stage 1, rounding (registered):
  - r = round-half-to-even(din / 2^DROP_LSB), computed in IN_WIDTH-DROP_LSB+1 bits so no internal wrap.
  - Tie (dropped bits == 100..0): round up iff the kept LSB is 1.
  - Negative values are treated symmetrically: -1.5 -> -2, -2.5 -> -2.
- Stage 2, saturation (registered):
  - r > 2^(OUT_WIDTH-1)-1 clamps to max; r < -2^(OUT_WIDTH-1) clamps to min.
  - Any clamp sets sat_flag on the same edge the sample enters the FIFO.
- FIFO write on stage-2 valid.
- Latency:
  - valid_in kept sample at edge N.
  - Stage-1 register at N+1, stage-2 at N+2, FIFO write at N+3.
  - out_valid=1 in the cycle after edge N+3 if the FIFO was empty.
  - Throughput: one sample per clock (DECIM=1).
- FIFO:
  - Pop when out_valid & out_ready.
  - dout = head entry when out_valid=1, forced to 0 when empty.
  - Full and write without pop: sample dropped, overflow set, contents unchanged.
  - Full with simultaneous write and pop: both performed, level unchanged, no overflow.
  - Empty with write: no bypass, so the sample is visible the next cycle; a pop is impossible while empty.
  - Pointers wrap modulo FIFO_DEPTH; fifo_level is exact, 0..FIFO_DEPTH.
- Flags:
  - flags_clr clears both sticky flags.
  - A set event in the same cycle as flags_clr wins, so the flag stays 1.
- Reset mid-operation discards FIFO contents and pipeline; the phase counter restarts at 0.

Test Plan:
- Rounding, DECIM=1, default widths: din = 1536, 2560, -1536, -2560, 1535 -> dout = 2, 2, -2, -2, 1; sat_flag stays 0.
- Saturation: din = 2^25-1 -> dout = 32767, sat_flag=1; din = -2^25 -> dout = -32768 (no new clamp); flags_clr -> sat_flag=0. Also flags_clr asserted in the same cycle as a new clamp -> sat_flag stays 1.
- Decimation: DECIM=4, phase_sel=2, din = k*1024 for k=0..11 continuous -> dout sequence 2, 6, 10. Change phase_sel to 0 mid-frame -> takes effect only at the next wrap; exactly one sample per frame.
- Backpressure: out_ready=0, 9 kept samples -> fifo_level=8, overflow=1, 9th lost. Then out_ready=1 -> first 8 values drained in order, out_valid drops after the 8th.
- Full with simultaneous push and pop: level held at 8, overflow stays 0, order preserved.
- Latency/reset: single sample at edge N -> out_valid at N+3. rst asserted while 3 entries are queued and one is in the pipeline -> next cycle out_valid=0, fifo_level=0, flags=0, dout=0; the next kept sample uses phase counter 0.
